// File: rtl/in1536_out128_pkg.sv
// rtl/in1536_out128_pkg.sv - shared width constants for the 1536/128 packer and unpacker pair
package in1536_out128_pkg;
  localparam int IN_W_DEF  = 1536;
  localparam int OUT_W_DEF = 128;
  localparam int BEATS_DEF = IN_W_DEF / OUT_W_DEF;

  // Counter width that stays at least one bit for single-value ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/in1536_out128_word_slot_buf.sv
// rtl/in1536_out128_word_slot_buf.sv - two-slot ping-pong word store with pointers and occupancy
module in1536_out128_word_slot_buf #(
  parameter int W = 1536
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_valid,
  input  logic [W-1:0] i_wr_data,
  output logic         o_wr_ready,
  input  logic         i_rd_done,
  output logic         o_rd_valid,
  output logic [W-1:0] o_rd_data
);
  logic [W-1:0] r_slot [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_ready;
  logic         w_wr;
  logic         w_rd;
  logic [1:0]   w_count_nxt;

  assign w_wr = i_wr_valid & r_ready;
  assign w_rd = i_rd_done & (r_count != 2'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is registered from the post-edge occupancy, so it never waits on tvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= ~r_wr_ptr;
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_slot[r_wr_ptr] <= i_wr_data;
  end

  assign o_wr_ready = r_ready;
  assign o_rd_valid = (r_count != 2'd0);
  assign o_rd_data  = r_slot[r_rd_ptr];
endmodule

// File: rtl/in1536_out128.sv
// rtl/in1536_out128.sv - wide-word to narrow-beat unpacker, LS slice first, 1 beat/cycle
// Defining IN1536_OUT128_TLAST_EN adds m_axis_tlast and a per-frame word counter.
module in1536_out128
  import in1536_out128_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int FRAME_WORDS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
`ifdef IN1536_OUT128_TLAST_EN
  output logic             m_axis_tlast,
`endif
  input  logic             m_axis_tready
);
  localparam int BEATS  = IN_W / OUT_W;
  localparam int BEAT_W = cnt_w(BEATS);

  if ((IN_W % OUT_W) != 0 || FRAME_WORDS < 1) begin : g_cfg_err
    $error("in1536_out128: IN_W must be a multiple of OUT_W and FRAME_WORDS >= 1");
  end

  logic              w_rd_valid;
  logic [IN_W-1:0]   w_rd_data;
  logic              w_out_fire;
  logic              w_last_beat;
  logic              w_rd_done;
  logic [BEAT_W-1:0] r_beat;

  assign w_out_fire  = w_rd_valid & m_axis_tready;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_rd_done   = w_out_fire & w_last_beat;

  in1536_out128_word_slot_buf #(
    .W(IN_W)
  ) u_slot_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (s_axis_tvalid),
    .i_wr_data  (s_axis_tdata),
    .o_wr_ready (s_axis_tready),
    .i_rd_done  (w_rd_done),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_out_fire) begin
      r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
    end
  end

  assign m_axis_tvalid = w_rd_valid;
  assign m_axis_tdata  = w_rd_data[r_beat*OUT_W +: OUT_W];

`ifdef IN1536_OUT128_TLAST_EN
  localparam int WORD_W = cnt_w(FRAME_WORDS);
  logic [WORD_W-1:0] r_word;
  logic              w_frame_end;

  assign w_frame_end = (r_word == WORD_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (w_rd_done) begin
      r_word <= w_frame_end ? '0 : r_word + WORD_W'(1);
    end
  end

  assign m_axis_tlast = w_rd_valid & w_last_beat & w_frame_end;
`endif
endmodule

// File: doc/in1536_out128.md
IN1536_OUT128 -- requirements
Module: in1536_out128

Interface
REQ-001 Parameter IN_W, default 1536, input word width in bits.
REQ-002 Parameter OUT_W, default 128, output beat width; IN_W SHALL be an integer multiple of OUT_W; BEATS = IN_W/OUT_W (12 by default).
REQ-003 Parameter FRAME_WORDS, default 1, number of input words per frame (used only with TLAST, REQ-031).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_axis_tdata  input  IN_W  wide word from the upstream packer.
REQ-007 s_axis_tvalid  input  1  upstream word valid.
REQ-008 s_axis_tready  output  1  block can accept a word this cycle.
REQ-009 m_axis_tdata  output  OUT_W  current output beat.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  downstream accepts the beat.
REQ-012 m_axis_tlast  output  1  present only when TLAST is compiled in (REQ-031).

Function
REQ-013 Input transfer: s_axis_tvalid & s_axis_tready high at a rising edge; output transfer: m_axis_tvalid & m_axis_tready high at a rising edge.
REQ-014 Storage: two IN_W-bit word slots (ping-pong), a write pointer, a read pointer, a 2-bit occupancy count (0..2) and a beat counter 0..BEATS-1.
REQ-015 s_axis_tready SHALL be registered and high iff occupancy < 2 after the current edge's updates; it SHALL NOT combinationally depend on s_axis_tvalid.
REQ-016 Beat k of a word (k = 0 first) SHALL be word[k*OUT_W +: OUT_W], i.e. least-significant slice first, restoring the arrival order of the upstream packer.
REQ-017 m_axis_tvalid SHALL be high iff occupancy > 0; m_axis_tdata SHALL select the read slot's beat-counter slice.
REQ-018 Latency: a word accepted into an empty block at edge N SHALL present beat 0 valid from edge N onward (visible in the following cycle).
REQ-019 On each output transfer the beat counter SHALL increment; on the transfer of beat BEATS-1 it SHALL wrap to 0, the read pointer SHALL toggle and occupancy SHALL decrement.
REQ-020 Simultaneous input transfer and final-beat output transfer SHALL leave occupancy unchanged and s_axis_tready high; no data loss, no bubble.
REQ-021 With a buffered second word, beat 0 of that word SHALL follow beat BEATS-1 of the previous word in the next cycle (full throughput: 1 beat/cycle).
REQ-022 m_axis_tdata and m_axis_tvalid SHALL hold stable while m_axis_tvalid & ~m_axis_tready.
REQ-023 When occupancy is 2, s_axis_tready SHALL be low and s_axis_tdata SHALL be ignored.
REQ-024 Slot contents are written only on input transfer; the slot being read is never overwritten.

Reset
REQ-025 Asserting rst SHALL immediately clear occupancy, pointers and beat counter; m_axis_tvalid = 0, s_axis_tready = 0 while rst is high.
REQ-026 s_axis_tready SHALL rise on the first rising edge after rst deasserts.
REQ-027 Reset mid-word SHALL discard all buffered data; no partial beats are emitted afterwards.
REQ-028 Slot data registers need not be reset; m_axis_tdata is don't-care while m_axis_tvalid = 0.

Configuration
REQ-029 Macro IN1536_OUT128_TLAST_EN SHALL compile in frame-end signalling.
REQ-030 Without it: no m_axis_tlast port, no word counter.
REQ-031 With it: a word counter 0..FRAME_WORDS-1 advances on each word completion; m_axis_tlast SHALL be high with the last beat of the word that completes a frame, else low; counter reset to 0 by rst.

Structure
REQ-032 A shared package SHALL hold the width constants (IN_W 1536, OUT_W 128, BEATS 12) also used by the upstream in128_out1536 packer.
REQ-033 One sub-module, word_slot_buf (two-slot ping-pong storage with pointers and occupancy), is natural; beat selection and counter stay in the top.

Verification
REQ-034 Word 0x…0B_0A_…_01_00 (beat k = value k in every byte), m_axis_tready always 1 -> beats 0..11 on 12 consecutive cycles, beat k all bytes = k.
REQ-035 Three back-to-back words, m_axis_tready = 1 -> 36 beats with no gap; s_axis_tready never low for more than the cycles needed to free a slot.
REQ-036 m_axis_tready low for 20 cycles at beat 5 while upstream keeps valid -> beat 5 held stable, occupancy reaches 2, s_axis_tready = 0, no beat lost or duplicated.
REQ-037 rst pulsed during beat 7 of a word with a second word buffered -> m_axis_tvalid drops at once, nothing further emitted until a new word is accepted.
REQ-038 TLAST_EN, FRAME_WORDS = 3, six words -> m_axis_tlast high only on beat 11 of words 3 and 6.
